config_frame_loader: RTL and testbench
======================================

CONFIG_FRAME_LOADER -- requirements
Module: config_frame_loader

Interface
REQ-001 The block SHALL have parameter FrameBitsPerRow, default 32: width of one frame data word.
REQ-002 The block SHALL have parameter RowSelectWidth, default 5: width of the row select bus.
REQ-003 The block SHALL have parameter NumberOfRows, default 15: data words per frame; valid rows are 1..NumberOfRows.
REQ-004 The block SHALL have parameter MaxFramesPerCol, default 20: number of frame strobe lines.
REQ-005 The block SHALL have parameter ColSelectWidth, default 5: width of the column select field.
REQ-006 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port RESET, input, 1 bit: synchronous reset, active-high.
REQ-008 The block SHALL have port WriteData, input, 32 bits: configuration word (header or row data).
REQ-009 The block SHALL have port WriteStrobe, input, 1 bit: WriteData is valid.
REQ-010 The block SHALL have port WriteReady, output, 1 bit: a word is accepted when WriteStrobe and WriteReady are both high.
REQ-011 The block SHALL have port FrameData_O, output, FrameBitsPerRow bits: row data broadcast to all row registers.
REQ-012 The block SHALL have port RowSelect_O, output, RowSelectWidth bits: target row; 0 means no row.
REQ-013 The block SHALL have port ColSelect_O, output, ColSelectWidth bits: column of the current frame.
REQ-014 The block SHALL have port FrameStrobe_O, output, MaxFramesPerCol bits: one-hot frame write pulse.
REQ-015 The block SHALL have port Error_O, output, 1 bit: sticky bad-header flag.

Function
REQ-016 The state machine SHALL have the states HEADER, DATA, DISCARD and STROBE, with the row counter counting 1..NumberOfRows.
REQ-017 In HEADER, an accepted word SHALL be decoded as column = WriteData[31:27] and frame index = WriteData[26:22], with bits [21:0] ignored.
REQ-018 A header whose frame index is below MaxFramesPerCol SHALL latch ColSelect_O and the index, set the row counter to 1, and move to DATA.
REQ-019 A header whose frame index is MaxFramesPerCol or greater SHALL set Error_O, set the row counter to 1, and move to DISCARD.
REQ-020 In DATA, a word accepted at edge k SHALL drive FrameData_O = WriteData and RowSelect_O = row counter during cycle k+1, for exactly one cycle, and SHALL then increment the row counter.
REQ-021 In any cycle without a data acceptance, RowSelect_O SHALL be 0 and FrameData_O SHALL hold its last value.
REQ-022 Gaps in WriteStrobe SHALL stall the frame without loss; no timeout applies.
REQ-023 Accepting the word for row NumberOfRows SHALL move the state machine to STROBE.
REQ-024 STROBE SHALL last exactly one cycle with WriteReady low, and FrameStrobe_O SHALL be the registered one-hot of the frame index, asserted during the following cycle only.
REQ-025 The state machine SHALL return from STROBE to HEADER.
REQ-026 WriteReady SHALL be high in HEADER, DATA and DISCARD.
REQ-027 A header accepted in the cycle in which FrameStrobe_O is high SHALL be legal, so frames can be loaded back-to-back.
REQ-028 DISCARD SHALL consume NumberOfRows words with RowSelect_O = 0 and no strobe, then return to HEADER.
REQ-029 ColSelect_O SHALL hold its value until the next valid header.
REQ-030 The row counter SHALL never present 0 or a value greater than NumberOfRows on RowSelect_O.
REQ-031 RowSelect_O SHALL be nonzero in at most one of any two consecutive cycles' worth of accepted words, with exactly one row per accepted word.
REQ-032 Error_O SHALL be cleared only by RESET.

Reset
REQ-033 When RESET is high at a rising edge, state SHALL become HEADER and the row counter 1.
REQ-034 On reset, FrameData_O, RowSelect_O, ColSelect_O, FrameStrobe_O and Error_O SHALL be 0.
REQ-035 On reset, WriteReady SHALL be 1 in the cycle after reset.
REQ-036 A reset during DATA or STROBE SHALL abort the frame, and no FrameStrobe_O pulse SHALL follow.
REQ-037 RESET SHALL have priority over WriteStrobe in the same cycle.

Structure
REQ-038 A shared package config_pkg SHALL hold the state encoding, the header field bit positions (COL_MSB/LSB, FRAME_MSB/LSB) and the default parameter values.
REQ-039 One sub-module, frame_strobe_decoder, SHALL implement the parameterised binary-to-one-hot decoder, with a registered output and an enable input.
REQ-040 There SHALL be no other hierarchy in the block.

Verification
REQ-041 A bench SHALL cover valid load: header col=3 frame=2, then 15 words 0x1000_0001..0x1000_000F back-to-back -> RowSelect_O steps 1..15 one cycle after each accept with matching data, then FrameStrobe_O=0x00004 for one cycle, ColSelect_O=3.
REQ-042 A bench SHALL cover stalls: the same frame with WriteStrobe low for 3 cycles between rows 7 and 8 -> RowSelect_O=0 during the gap, data and strobe otherwise identical, and no row skipped or repeated.
REQ-043 A bench SHALL cover a bad header: frame index 25 followed by 15 words -> Error_O=1 from the cycle after the header, RowSelect_O stays 0, no strobe; a following valid frame loads normally and Error_O stays 1.
REQ-044 A bench SHALL cover back-to-back frames: a header asserted in the strobe cycle of the previous frame -> accepted, second frame's row 1 appears 2 cycles later, and each frame gets exactly one strobe.
REQ-045 A bench SHALL cover reset mid-frame: RESET high after row 9 -> all outputs 0 next cycle, no strobe, and the next 16 words (header+15) produce a complete correct frame.
REQ-046 A bench SHALL cover the STROBE cycle: WriteStrobe held high through STROBE -> WriteReady=0 in that cycle, and no word is consumed or dropped.

Source files
------------

// File: rtl/config_pkg.sv
// Shared definitions for the configuration frame loader: state encoding,
// header field positions and default parameter values.
package config_pkg;

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_DATA    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_STROBE  = 2'd3
  } state_e;

  localparam int COL_MSB     = 31;
  localparam int COL_LSB     = 27;
  localparam int FRAME_MSB   = 26;
  localparam int FRAME_LSB   = 22;
  localparam int FRAME_IDX_W = FRAME_MSB - FRAME_LSB + 1;

  localparam int DEF_FRAME_BITS_PER_ROW  = 32;
  localparam int DEF_ROW_SELECT_WIDTH    = 5;
  localparam int DEF_NUMBER_OF_ROWS      = 15;
  localparam int DEF_MAX_FRAMES_PER_COL  = 20;
  localparam int DEF_COL_SELECT_WIDTH    = 5;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Binary-to-one-hot frame strobe decoder with a registered output; the
// output is all zeros whenever the enable is low.
module frame_strobe_decoder
  import config_pkg::*;
#(
  parameter int IdxWidth = FRAME_IDX_W,
  parameter int NumOut   = DEF_MAX_FRAMES_PER_COL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [IdxWidth-1:0] idx,
  output logic [NumOut-1:0]   onehot_o
);

  logic [NumOut-1:0] onehot_d;
  logic [NumOut-1:0] onehot_q;

  // Decode the index; out-of-range indices produce no strobe.
  always_comb begin
    onehot_d = '0;
    for (int i = 0; i < NumOut; i++) begin
      if (en && (32'(idx) == $unsigned(i))) begin
        onehot_d[i] = 1'b1;
      end else begin
        onehot_d[i] = 1'b0;
      end
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      onehot_q <= '0;
    end else begin
      onehot_q <= onehot_d;
    end
  end

  assign onehot_o = onehot_q;

endmodule

// File: rtl/config_frame_loader.sv
// Loads configuration frames (one header word plus NumberOfRows data words)
// from a ready/strobe word stream and drives row, column and frame strobes.
module config_frame_loader
  import config_pkg::*;
#(
  parameter int FrameBitsPerRow = DEF_FRAME_BITS_PER_ROW,
  parameter int RowSelectWidth  = DEF_ROW_SELECT_WIDTH,
  parameter int NumberOfRows    = DEF_NUMBER_OF_ROWS,
  parameter int MaxFramesPerCol = DEF_MAX_FRAMES_PER_COL,
  parameter int ColSelectWidth  = DEF_COL_SELECT_WIDTH
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [31:0]                WriteData,
  input  logic                       WriteStrobe,
  output logic                       WriteReady,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  output logic [RowSelectWidth-1:0]  RowSelect_O,
  output logic [ColSelectWidth-1:0]  ColSelect_O,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  output logic                       Error_O
);

  localparam logic [RowSelectWidth-1:0] FIRST_ROW  = RowSelectWidth'(1);
  localparam logic [RowSelectWidth-1:0] LAST_ROW   = RowSelectWidth'(NumberOfRows);
  localparam logic [31:0]               MAX_FRAMES = 32'(MaxFramesPerCol);

  state_e                     state_d, state_q;
  logic [RowSelectWidth-1:0]  row_cnt_d, row_cnt_q;
  logic [RowSelectWidth-1:0]  row_sel_d, row_sel_q;
  logic [FrameBitsPerRow-1:0] frame_data_d, frame_data_q;
  logic [ColSelectWidth-1:0]  col_d, col_q;
  logic [FRAME_IDX_W-1:0]     frame_idx_d, frame_idx_q;
  logic                       error_d, error_q;
  logic                       ready_d, ready_q;

  logic                       accept_s;
  logic                       strobe_en_s;
  logic [FRAME_IDX_W-1:0]     hdr_frame_s;
  logic [ColSelectWidth-1:0]  hdr_col_s;

  assign accept_s    = WriteStrobe & ready_q;
  assign hdr_frame_s = WriteData[FRAME_MSB:FRAME_LSB];
  assign hdr_col_s   = ColSelectWidth'(WriteData[COL_MSB:COL_LSB]);
  assign strobe_en_s = (state_q == ST_STROBE);

  // Next-state and datapath decode; RowSelect defaults to 0 so it pulses
  // for exactly one cycle per accepted data word.
  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    row_sel_d    = '0;
    frame_data_d = frame_data_q;
    col_d        = col_q;
    frame_idx_d  = frame_idx_q;
    error_d      = error_q;

    case (state_q)
      ST_HEADER: begin
        if (accept_s) begin
          row_cnt_d = FIRST_ROW;
          if (32'(hdr_frame_s) < MAX_FRAMES) begin
            col_d       = hdr_col_s;
            frame_idx_d = hdr_frame_s;
            state_d     = ST_DATA;
          end else begin
            error_d = 1'b1;
            state_d = ST_DISCARD;
          end
        end else begin
          state_d = ST_HEADER;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          frame_data_d = WriteData[FrameBitsPerRow-1:0];
          row_sel_d    = row_cnt_q;
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d = FIRST_ROW;
            state_d   = ST_STROBE;
          end else begin
            row_cnt_d = row_cnt_q + FIRST_ROW;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DISCARD: begin
        if (accept_s) begin
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d = FIRST_ROW;
            state_d   = ST_HEADER;
          end else begin
            row_cnt_d = row_cnt_q + FIRST_ROW;
          end
        end else begin
          state_d = ST_DISCARD;
        end
      end
      ST_STROBE: begin
        state_d = ST_HEADER;
      end
      default: begin
        state_d   = ST_HEADER;
        row_cnt_d = FIRST_ROW;
      end
    endcase

    // Ready is registered, so it is derived from the state being entered.
    ready_d = (state_d != ST_STROBE);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_HEADER;
      row_cnt_q    <= FIRST_ROW;
      row_sel_q    <= '0;
      frame_data_q <= '0;
      col_q        <= '0;
      frame_idx_q  <= '0;
      error_q      <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      row_sel_q    <= row_sel_d;
      frame_data_q <= frame_data_d;
      col_q        <= col_d;
      frame_idx_q  <= frame_idx_d;
      error_q      <= error_d;
      ready_q      <= ready_d;
    end
  end

  frame_strobe_decoder #(
    .IdxWidth (FRAME_IDX_W),
    .NumOut   (MaxFramesPerCol)
  ) u_strobe_dec (
    .clk      (CLK),
    .rst      (RESET),
    .en       (strobe_en_s),
    .idx      (frame_idx_q),
    .onehot_o (FrameStrobe_O)
  );

  assign WriteReady  = ready_q;
  assign FrameData_O = frame_data_q;
  assign RowSelect_O = row_sel_q;
  assign ColSelect_O = col_q;
  assign Error_O     = error_q;

endmodule

// File: tb/tb_config_frame_loader.sv
// Scoreboard bench for config_frame_loader: a frame-level model queues the
// expected row writes and strobes, and a negedge monitor checks them.
module tb_config_frame_loader;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] WriteData = 32'h0;
  logic        WriteStrobe = 1'b0;
  logic        WriteReady;
  logic [31:0] FrameData_O;
  logic [4:0]  RowSelect_O;
  logic [4:0]  ColSelect_O;
  logic [19:0] FrameStrobe_O;
  logic        Error_O;

  config_frame_loader dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .WriteData     (WriteData),
    .WriteStrobe   (WriteStrobe),
    .WriteReady    (WriteReady),
    .FrameData_O   (FrameData_O),
    .RowSelect_O   (RowSelect_O),
    .ColSelect_O   (ColSelect_O),
    .FrameStrobe_O (FrameStrobe_O),
    .Error_O       (Error_O)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic [4:0]  row;
    logic [31:0] data;
    logic [4:0]  col;
  } row_t;

  typedef struct {
    int          cyc;
    logic [19:0] onehot;
    logic [4:0]  col;
  } stb_t;

  row_t rq[$];
  stb_t sq[$];
  row_t mon_row;
  stb_t mon_stb;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  // Frame-level reference model state.
  int          ready_low_cyc = -1;
  bit          err_m = 1'b0;
  int          err_from = 0;
  logic [31:0] last_data = 32'h0;
  bit          started = 1'b0;
  int          words_left = 0;
  int          row_m = 0;
  bit          valid_m = 1'b0;
  logic [4:0]  col_m = 5'd0;
  logic [4:0]  fr_m = 5'd0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of one accepted word, called just before the accepting edge.
  task automatic model_accept(input logic [31:0] w);
    logic [19:0] oh;
    if (words_left == 0) begin
      if (w[26:22] < 5'd20) begin
        valid_m = 1'b1;
        col_m   = w[31:27];
        fr_m    = w[26:22];
      end else begin
        valid_m = 1'b0;
        if (!err_m) begin
          err_m    = 1'b1;
          err_from = cyc + 1;
        end
      end
      words_left = 15;
      row_m      = 1;
    end else begin
      if (valid_m) rq.push_back('{cyc + 1, 5'(row_m), w, col_m});
      row_m++;
      words_left--;
      if (words_left == 0 && valid_m) begin
        oh = 20'h0;
        oh[fr_m] = 1'b1;
        sq.push_back('{cyc + 2, oh, col_m});
        ready_low_cyc = cyc + 1;
      end
    end
  endtask

  task automatic send(input logic [31:0] w);
    int waited = 0;
    @(negedge CLK);
    WriteData   = w;
    WriteStrobe = 1'b1;
    while (WriteReady !== 1'b1 && waited < 4) begin
      @(negedge CLK);
      waited++;
    end
    if (WriteReady !== 1'b1) check("accept_timeout", {63'h0, WriteReady}, 64'h1);
    else model_accept(w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      WriteStrobe = 1'b0;
      WriteData   = $urandom;
    end
  endtask

  task automatic send_frame(input logic [4:0] col, input logic [4:0] fr,
                            input logic [31:0] base, input int gap_row, input int gap_len);
    send({col, fr, 22'($urandom)});
    for (int r = 1; r <= 15; r++) begin
      send(base + 32'(r));
      if (r == gap_row) idle(gap_len);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET       = 1'b1;
    WriteStrobe = 1'b0;
    @(posedge CLK);
    #1;
    rq.delete();
    sq.delete();
    err_m         = 1'b0;
    ready_low_cyc = -1;
    last_data     = 32'h0;
    words_left    = 0;
    started       = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("rst_data",   64'(FrameData_O),   64'h0);
    check("rst_row",    64'(RowSelect_O),   64'h0);
    check("rst_col",    64'(ColSelect_O),   64'h0);
    check("rst_strobe", 64'(FrameStrobe_O), 64'h0);
    check("rst_error",  64'(Error_O),       64'h0);
    check("rst_ready",  64'(WriteReady),    64'h1);
  endtask

  // Monitor: compares every cycle's outputs against the model queues.
  always @(negedge CLK) begin
    if (started) begin
      check("ready", 64'(WriteReady), 64'(cyc != ready_low_cyc));
      check("error", 64'(Error_O), 64'(err_m && cyc >= err_from));
      if (RowSelect_O != 5'd0) begin
        if (rq.size() == 0) begin
          check("unexpected_row", 64'(RowSelect_O), 64'h0);
        end else begin
          mon_row = rq.pop_front();
          check("row_cycle", 64'(cyc), 64'(mon_row.cyc));
          check("row_sel", 64'(RowSelect_O), 64'(mon_row.row));
          check("row_data", 64'(FrameData_O), 64'(mon_row.data));
          check("row_col", 64'(ColSelect_O), 64'(mon_row.col));
          last_data = mon_row.data;
        end
      end else begin
        check("data_hold", 64'(FrameData_O), 64'(last_data));
        if (rq.size() != 0 && rq[0].cyc < cyc) begin
          check("missed_row", 64'(RowSelect_O), 64'(rq[0].row));
          void'(rq.pop_front());
        end
      end
      if (FrameStrobe_O != 20'h0) begin
        if (sq.size() == 0) begin
          check("unexpected_strobe", 64'(FrameStrobe_O), 64'h0);
        end else begin
          mon_stb = sq.pop_front();
          check("strobe_cycle", 64'(cyc), 64'(mon_stb.cyc));
          check("strobe_onehot", 64'(FrameStrobe_O), 64'(mon_stb.onehot));
          check("strobe_col", 64'(ColSelect_O), 64'(mon_stb.col));
        end
      end else if (sq.size() != 0 && sq[0].cyc < cyc) begin
        check("missed_strobe", 64'(FrameStrobe_O), 64'(sq[0].onehot));
        void'(sq.pop_front());
      end
    end
  end

  initial begin
    do_reset();

    // Valid load, then a back-to-back frame whose header waits through STROBE.
    send_frame(5'd3, 5'd2, 32'h1000_0000, 0, 0);
    send_frame(5'd7, 5'd19, 32'h2000_0000, 0, 0);

    // Stall of three cycles between rows 7 and 8.
    send_frame(5'd3, 5'd2, 32'h1000_0000, 7, 3);
    idle(2);

    // Bad headers (index 25 and boundary 20), then a valid frame.
    send_frame(5'd4, 5'd25, 32'h3000_0000, 0, 0);
    send_frame(5'd1, 5'd0, 32'h4000_0000, 0, 0);
    send_frame(5'd2, 5'd20, 32'h5000_0000, 0, 0);
    send_frame(5'd31, 5'd1, 32'h6000_0000, 0, 0);

    // Reset after row 9, then a complete frame.
    send({5'd6, 5'd5, 22'h0});
    for (int r = 1; r <= 9; r++) send(32'h7000_0000 + 32'(r));
    do_reset();
    send_frame(5'd6, 5'd5, 32'h8000_0000, 0, 0);

    // Randomized frames with random gaps and some bad headers.
    for (int f = 0; f < 20; f++) begin
      send_frame(5'($urandom), 5'($urandom_range(0, 31)), $urandom,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 4)));
    end

    idle(6);
    check("rows_drained", 64'(rq.size()), 64'h0);
    check("strobes_drained", 64'(sq.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
